// File: rtl/imem_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
//   IMemAddrT        : byte address into the instruction spram
//   IMemDataT        : one instruction word as returned by spram data_out
//   FetchEntryT      : queued fetch result {pc, instr}
//   RESET_PC_DEFAULT : default first fetch address after reset
//   align_word()     : clears the byte-offset bits of an address
package imem_fetch_pkg;

  localparam int IMEM_ADDR_W = 16;
  localparam int IMEM_DATA_W = 32;

  typedef logic [IMEM_ADDR_W-1:0] IMemAddrT;
  typedef logic [IMEM_DATA_W-1:0] IMemDataT;

  typedef struct packed {
    IMemAddrT pc;
    IMemDataT instr;
  } FetchEntryT;

  localparam IMemAddrT RESET_PC_DEFAULT = '0;

  function automatic IMemAddrT align_word(input IMemAddrT addr);
    return {addr[IMEM_ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/imem_fetch_if.sv
// Fetch-to-decode handshake bundle.
//   instr_valid : head entry valid          (fetch -> decode)
//   instr_ready : decode accepts head entry (decode -> fetch)
//   instr       : head instruction word     (fetch -> decode)
//   instr_pc    : byte address of instr     (fetch -> decode)
// Modports: master = fetch side, slave = decode side.
interface imem_fetch_if;
  import imem_fetch_pkg::*;

  logic     instr_valid;
  logic     instr_ready;
  IMemDataT instr;
  IMemAddrT instr_pc;

  modport master (
    output instr_valid,
    output instr,
    output instr_pc,
    input  instr_ready
  );

  modport slave (
    input  instr_valid,
    input  instr,
    input  instr_pc,
    output instr_ready
  );

endinterface

// File: rtl/imem_fetch_queue.sv
// Two-entry FIFO of fetched words feeding decode.
//   clk, reset_n : clock, asynchronous active-low reset
//   push, din    : enqueue din at the edge
//   pop          : drop the head entry at the edge
//   flush        : empty the queue at the edge (wins over push/pop)
//   head         : registered head entry (entry 0)
//   count        : number of valid entries, 0..2
// Organised as a 2-deep shift register so the head is always entry 0 and
// comes straight from a flop. The caller guarantees no push when full
// unless the same edge pops, and no pop when empty.
module imem_fetch_queue
  import imem_fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic       push,
  input  FetchEntryT din,
  input  logic       pop,
  input  logic       flush,
  output FetchEntryT head,
  output logic [1:0] count
);

  FetchEntryT entry0;
  FetchEntryT entry1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      entry0 <= '0;
      entry1 <= '0;
      count  <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      unique case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= din;
          else               entry1 <= din;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind whatever stays.
          if (count == 2'd2) begin
            entry0 <= entry1;
            entry1 <= din;
          end else begin
            entry0 <= din;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

endmodule

// File: rtl/imem_fetch.sv
// Instruction fetch stage sitting directly in front of the spram.
//   clk            : system clock (shared with spram)
//   reset_n        : asynchronous active-low reset
//   mem_addr       : spram address; spram returns the word one edge later
//   mem_data       : spram data_out for the address registered last edge
//   redirect_valid : load redirect_pc, flushing queue and in-flight fetch
//   redirect_pc    : redirect target (low two bits ignored)
//   fetch          : decode handshake (instr_valid/ready, instr, instr_pc)
// The spram reads every edge; a fetch is "issued" when this block intends
// to keep the word coming back. Issue is throttled so that queued words
// plus the in-flight word never exceed the queue depth, which makes every
// response pushable without back-pressure.
module imem_fetch
  import imem_fetch_pkg::*;
#(
  parameter IMemAddrT RESET_PC = RESET_PC_DEFAULT,
  // Queue storage is a fixed 2-entry structure; DEPTH only sets the issue limit.
  parameter int       DEPTH    = 2
) (
  input  logic     clk,
  input  logic     reset_n,
  output IMemAddrT mem_addr,
  input  IMemDataT mem_data,
  input  logic     redirect_valid,
  input  IMemAddrT redirect_pc,
  imem_fetch_if.master fetch
);

  IMemAddrT   pc_q;
  logic       inflight_q;
  IMemAddrT   inflight_pc_q;

  logic       pop;
  logic       push;
  logic       issue;
  logic [2:0] occ;
  logic [1:0] q_count;
  FetchEntryT q_head;
  FetchEntryT q_din;

  // While reset is asserted the address is pinned regardless of redirect.
  assign mem_addr = !reset_n        ? RESET_PC :
                    redirect_valid  ? align_word(redirect_pc) :
                                      pc_q;

  // A redirect hides the head and cancels the pop so decode never consumes
  // a word from the path being abandoned.
  assign fetch.instr_valid = (q_count != 2'd0) && !redirect_valid;
  assign fetch.instr       = q_head.instr;
  assign fetch.instr_pc    = q_head.pc;

  assign pop   = fetch.instr_valid && fetch.instr_ready;
  assign push  = inflight_q && !redirect_valid;
  assign q_din = '{pc: inflight_pc_q, instr: mem_data};

  // pop implies q_count >= 1, so this never underflows.
  assign occ   = {1'b0, q_count} + {2'b00, inflight_q} - {2'b00, pop};
  assign issue = redirect_valid || (occ < 3'(DEPTH));

  // Edge: register the issued address; the spram answers next cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= RESET_PC;
    end else begin
      inflight_q <= issue;
      if (issue) begin
        pc_q          <= mem_addr + IMemAddrT'(4);
        inflight_pc_q <= mem_addr;
      end
    end
  end

  // Edge: capture the spram response into the decode queue.
  imem_fetch_queue u_queue (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .din     (q_din),
    .pop     (pop),
    .flush   (redirect_valid),
    .head    (q_head),
    .count   (q_count)
  );

endmodule

// File: tb/tb_imem_fetch.sv
module tb_imem_fetch;
  import imem_fetch_pkg::*;

  logic     clk;
  logic     reset_n;
  IMemAddrT mem_addr;
  IMemDataT mem_data;
  logic     redirect_valid;
  IMemAddrT redirect_pc;

  imem_fetch_if dec_if ();

  imem_fetch #(.RESET_PC(16'h0000), .DEPTH(2)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .mem_addr       (mem_addr),
    .mem_data       (mem_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .fetch          (dec_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // spram contents: word k at byte address 4k.
  function automatic IMemDataT word_at(input IMemAddrT a);
    return 32'h1000_0000 + 32'(a >> 2);
  endfunction

  // spram: registered read every edge, no enable.
  always @(posedge clk) mem_data <= word_at(mem_addr);

  typedef struct {
    logic     ready;
    logic     redir;
    IMemAddrT rpc;
    logic     exp_valid;
    IMemAddrT exp_pc;
    IMemAddrT exp_addr;
  } vec_t;

  localparam int NROWS = 28;
  vec_t rows [NROWS];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic rdy, input logic rd, input IMemAddrT rp,
                         input logic ev, input IMemAddrT epc, input IMemAddrT ea);
    rows[i].ready     = rdy;
    rows[i].redir     = rd;
    rows[i].rpc       = rp;
    rows[i].exp_valid = ev;
    rows[i].exp_pc    = epc;
    rows[i].exp_addr  = ea;
  endtask

  // Apply one row during a cycle, check mid-cycle, then advance past the next edge.
  task automatic do_row(input int i);
    dec_if.instr_ready = rows[i].ready;
    redirect_valid     = rows[i].redir;
    redirect_pc        = rows[i].rpc;
    @(negedge clk);
    check($sformatf("row%0d_valid", i), 32'(dec_if.instr_valid), 32'(rows[i].exp_valid));
    check($sformatf("row%0d_mem_addr", i), 32'(mem_addr), 32'(rows[i].exp_addr));
    if (rows[i].exp_valid) begin
      check($sformatf("row%0d_instr_pc", i), 32'(dec_if.instr_pc), 32'(rows[i].exp_pc));
      check($sformatf("row%0d_instr", i), dec_if.instr, word_at(rows[i].exp_pc));
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Cycle numbering starts at reset release.
    set_row( 0, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    set_row( 1, 1, 0, 16'h0000, 0, 16'h0000, 16'h0004);
    set_row( 2, 1, 0, 16'h0000, 1, 16'h0000, 16'h0008);
    set_row( 3, 1, 0, 16'h0000, 1, 16'h0004, 16'h000C);
    // stall cycles 4..8: head held at 8, queue fills, fetch stops at 16
    set_row( 4, 0, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row( 5, 0, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row( 6, 0, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row( 7, 0, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row( 8, 0, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row( 9, 1, 0, 16'h0000, 1, 16'h0008, 16'h0010);
    set_row(10, 1, 0, 16'h0000, 1, 16'h000C, 16'h0014);
    set_row(11, 0, 0, 16'h0000, 1, 16'h0010, 16'h0018);
    // redirect to 0x40 with the queue full (16, 20)
    set_row(12, 1, 1, 16'h0040, 0, 16'h0000, 16'h0040);
    set_row(13, 1, 0, 16'h0000, 0, 16'h0000, 16'h0044);
    set_row(14, 1, 0, 16'h0000, 1, 16'h0040, 16'h0048);
    // misaligned redirect during a stall, with 0x48 in flight
    set_row(15, 0, 1, 16'h0043, 0, 16'h0000, 16'h0040);
    set_row(16, 0, 0, 16'h0000, 0, 16'h0000, 16'h0044);
    set_row(17, 0, 0, 16'h0000, 1, 16'h0040, 16'h0048);
    set_row(18, 1, 0, 16'h0000, 1, 16'h0040, 16'h0048);
    set_row(19, 1, 0, 16'h0000, 1, 16'h0044, 16'h004C);
    set_row(20, 1, 0, 16'h0000, 1, 16'h0048, 16'h0050);
    // back-to-back redirects, last one (0xFFFC) wins, then wrap
    set_row(21, 1, 1, 16'h0100, 0, 16'h0000, 16'h0100);
    set_row(22, 1, 1, 16'hFFFE, 0, 16'h0000, 16'hFFFC);
    set_row(23, 1, 0, 16'h0000, 0, 16'h0000, 16'h0000);
    set_row(24, 1, 0, 16'h0000, 1, 16'hFFFC, 16'h0004);
    set_row(25, 1, 0, 16'h0000, 1, 16'h0000, 16'h0008);
    set_row(26, 1, 0, 16'h0000, 1, 16'h0004, 16'h000C);
    set_row(27, 1, 0, 16'h0000, 1, 16'h0008, 16'h0010);

    reset_n            = 1'b0;
    redirect_valid     = 1'b0;
    redirect_pc        = '0;
    dec_if.instr_ready = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", 32'(dec_if.instr_valid), 32'd0);
    check("reset_mem_addr", 32'(mem_addr), 32'h0000);
    check("reset_instr", dec_if.instr, 32'd0);
    check("reset_instr_pc", 32'(dec_if.instr_pc), 32'h0000);
    reset_n = 1'b1;

    for (int i = 0; i < NROWS; i++) do_row(i);

    // Reset asserted between edges while words are queued.
    check("pre_reset_valid", 32'(dec_if.instr_valid), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_valid", 32'(dec_if.instr_valid), 32'd0);
    check("async_reset_mem_addr", 32'(mem_addr), 32'h0000);
    check("async_reset_instr", dec_if.instr, 32'd0);
    check("async_reset_instr_pc", 32'(dec_if.instr_pc), 32'h0000);
    @(posedge clk);
    #1;
    check("held_reset_valid", 32'(dec_if.instr_valid), 32'd0);
    check("held_reset_mem_addr", 32'(mem_addr), 32'h0000);
    reset_n = 1'b1;

    // Stream after release must repeat the first stretch exactly.
    for (int i = 0; i < 12; i++) do_row(i);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
